core_bus_target: RTL
====================

Name: core_bus_target

Overview:
- Bus responder on the CPU side of the 6502-style core bus; the core is the initiator.
- Decodes one address window and converts each selected CPU cycle into a req/ack transaction on a downstream memory port of variable latency.
- Holds O_ready low until the transaction completes, stretching the CPU cycle, then presents read data.
- Unselected cycles are ignored: open bus, no stall.

Parameters:
- DEC_MASK, 16'hE000, address bits compared for selection
- DEC_MATCH, 16'h0000, selected when (I_addr & DEC_MASK) == DEC_MATCH
- MEM_AW, 13, downstream address width; O_mem_addr = I_addr[MEM_AW-1:0]
- TIMEOUT, 64, clocks in REQ before abort (used only with the optional feature)

Ports:
- I_clock  in  1  system clock, same clock as the CPU core
- I_reset  in  1  reset; synchronous, active-high
- I_addr  in  16  CPU address
- I_wr_data  in  8  CPU write data
- I_rdwr  in  1  1 = read, 0 = write
- I_phy2  in  1  CPU phase-2 clock indicator
- O_rd_data  out  8  data returned to the CPU
- O_ready  out  1  0 = stretch the current CPU cycle
- O_mem_req  out  1  downstream request, level
- O_mem_we  out  1  downstream write enable
- O_mem_addr  out  MEM_AW  downstream address
- O_mem_wdata  out  8  downstream write data
- I_mem_ack  in  1  downstream completion, one-clock pulse
- I_mem_rdata  in  8  downstream read data, valid with I_mem_ack
- O_err  out  1  timeout pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset, synchronous active-high, overrides everything including an in-flight request:
  - state IDLE, O_ready=1, O_rd_data=8'h00, O_mem_req=0, O_mem_we=0, O_mem_addr=0, O_mem_wdata=0, O_err=0.
  - Internal last_phy2=0.
- Internal last_phy2 is registered every clock. rise = I_phy2 & ~last_phy2; fall = ~I_phy2 & last_phy2.
- All outputs are registered. No combinational path from input to output.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On rise with selection true: capture I_addr, I_rdwr, I_wr_data.
  - Next clock: O_mem_req=1, O_mem_we=~I_rdwr, O_ready=0, go to REQ.
  - On rise with selection false: stay IDLE, O_ready stays 1, O_rd_data unchanged (open bus).
- REQ:
  - O_mem_addr, O_mem_we and O_mem_wdata are held stable while O_mem_req=1.
  - I_mem_ack is sampled on any clock with O_mem_req=1, including the first.
  - On ack: O_mem_req=0, O_ready=1; if read, O_rd_data <= I_mem_rdata (write leaves O_rd_data unchanged); go to DONE.
  - Further phy2 rise/fall edges while in REQ are ignored. The CPU repeats the same cycle, so there is no re-capture and no second request.
- DONE:
  - On fall, go to IDLE. This is the CPU sampling edge, with O_ready=1.
  - A rise while in DONE cannot occur before a fall. If it does, it is ignored.
- I_mem_ack while O_mem_req=0 is ignored.
- Latency:
  - Ack within 4 clocks of req assertion: O_ready is high again before the next phy2 fall, so the CPU sees no stall.
  - Otherwise the cycle stretches by whole 12-clock CPU periods until ack.
- Reset mid-REQ drops O_mem_req immediately. The downstream side must tolerate an abandoned request.

Optional Feature:
- Macro: CORE_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on REQ entry and increments each clock in REQ.
  - When it reaches TIMEOUT-1 with no ack: O_mem_req=0, O_rd_data=8'hFF (reads only), O_ready=1, one-clock O_err=1, go to DONE.
  - Ack in the same clock as expiry wins: normal completion, no O_err.
- Not defined: no counter; REQ waits indefinitely; O_err is constant 0.

Test Plan:
- Read hit, fast memory: I_addr=16'h0123, I_rdwr=1, ack 2 clocks after req with rdata=8'h5A -> O_mem_addr=13'h0123, O_mem_we=0, O_ready never sampled 0 at fall, O_rd_data=8'h5A, exactly one req.
- Write hit, slow memory: I_addr=16'h1FFF, I_wr_data=8'hC3, ack 20 clocks after req -> O_mem_we=1, O_mem_wdata=8'hC3, O_ready=0 across 2 phy2 falls, single req, O_rd_data unchanged.
- Miss: I_addr=16'h8000 -> O_mem_req stays 0, O_ready stays 1, O_rd_data holds the previous 8'h5A.
- Reset mid-REQ: I_reset=1 five clocks into REQ -> next clock O_mem_req=0, O_ready=1, O_rd_data=8'h00; an ack arriving afterwards is ignored.
- Stray ack: I_mem_ack=1 in IDLE -> no state change, O_rd_data unchanged.
- Timeout (CORE_BUS_TIMEOUT_EN, TIMEOUT=16): read of 16'h0040, no ack -> after 16 clocks in REQ, O_err pulses once, O_rd_data=8'hFF, O_ready=1, FSM returns to IDLE after the next fall.

Source files
------------

// File: rtl/core_bus_target_if.sv
// rtl/core_bus_target_if.sv - CPU-side and downstream memory signal bundle for core_bus_target
interface core_bus_target_if #(
    parameter int MEM_AW = 13
);
    logic [15:0]       I_addr;
    logic [7:0]        I_wr_data;
    logic              I_rdwr;
    logic              I_phy2;
    logic [7:0]        O_rd_data;
    logic              O_ready;
    logic              O_mem_req;
    logic              O_mem_we;
    logic [MEM_AW-1:0] O_mem_addr;
    logic [7:0]        O_mem_wdata;
    logic              I_mem_ack;
    logic [7:0]        I_mem_rdata;
    logic              O_err;

    modport slave (
        input  I_addr, I_wr_data, I_rdwr, I_phy2, I_mem_ack, I_mem_rdata,
        output O_rd_data, O_ready, O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata, O_err
    );

    modport master (
        output I_addr, I_wr_data, I_rdwr, I_phy2, I_mem_ack, I_mem_rdata,
        input  O_rd_data, O_ready, O_mem_req, O_mem_we, O_mem_addr, O_mem_wdata, O_err
    );
endinterface

// File: rtl/core_bus_target.sv
// rtl/core_bus_target.sv - 6502-style bus responder bridging one address window to a req/ack memory port
// Optional request timeout enabled by defining CORE_BUS_TIMEOUT_EN.
module core_bus_target #(
    parameter logic [15:0] DEC_MASK  = 16'hE000,
    parameter logic [15:0] DEC_MATCH = 16'h0000,
    parameter int          MEM_AW    = 13,
    parameter int          TIMEOUT   = 64
) (
    input  logic             I_clock,
    input  logic             I_reset,
    core_bus_target_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic              r_last_phy2;
    logic              w_rise, w_fall, w_sel;
    logic [7:0]        r_rd_data, w_rd_data_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;

    assign w_rise = bus.I_phy2 & ~r_last_phy2;
    assign w_fall = ~bus.I_phy2 & r_last_phy2;
    assign w_sel  = (bus.I_addr & DEC_MASK) == DEC_MATCH;

`ifdef CORE_BUS_TIMEOUT_EN
    logic [7:0] r_tcnt, w_tcnt_nxt;
    logic       r_err, w_err_nxt;
    logic       w_expire;

    assign w_expire = (r_tcnt == TO_LAST);
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TO_LAST;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_data_nxt   = r_rd_data;
        w_ready_nxt     = r_ready;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
`ifdef CORE_BUS_TIMEOUT_EN
        w_tcnt_nxt      = r_tcnt;
        w_err_nxt       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_rise && w_sel) begin
                    w_mem_addr_nxt  = bus.I_addr[MEM_AW-1:0];
                    w_mem_we_nxt    = ~bus.I_rdwr;
                    w_mem_wdata_nxt = bus.I_wr_data;
                    w_mem_req_nxt   = 1'b1;
                    w_ready_nxt     = 1'b0;
                    w_state_nxt     = S_REQ;
`ifdef CORE_BUS_TIMEOUT_EN
                    w_tcnt_nxt      = 8'd0;
`endif
                end
            end
            // Repeated phy2 edges while stretched belong to the same CPU cycle.
            S_REQ: begin
`ifdef CORE_BUS_TIMEOUT_EN
                w_tcnt_nxt = r_tcnt + 8'd1;
`endif
                if (bus.I_mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_ready_nxt   = 1'b1;
                    if (!r_mem_we) begin
                        w_rd_data_nxt = bus.I_mem_rdata;
                    end
                    w_state_nxt = S_DONE;
                end
`ifdef CORE_BUS_TIMEOUT_EN
                else if (w_expire) begin
                    w_mem_req_nxt = 1'b0;
                    w_ready_nxt   = 1'b1;
                    if (!r_mem_we) begin
                        w_rd_data_nxt = 8'hFF;
                    end
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state     <= S_IDLE;
            r_last_phy2 <= 1'b0;
            r_rd_data   <= 8'h00;
            r_ready     <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_last_phy2 <= bus.I_phy2;
            r_rd_data   <= w_rd_data_nxt;
            r_ready     <= w_ready_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

`ifdef CORE_BUS_TIMEOUT_EN
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_tcnt <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign bus.O_err = r_err;
`else
    assign bus.O_err = 1'b0;
`endif

    assign bus.O_rd_data   = r_rd_data;
    assign bus.O_ready     = r_ready;
    assign bus.O_mem_req   = r_mem_req;
    assign bus.O_mem_we    = r_mem_we;
    assign bus.O_mem_addr  = r_mem_addr;
    assign bus.O_mem_wdata = r_mem_wdata;
endmodule
